// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the Dcache req/addrOK/dataOK interface.
// Line refills and strongly-ordered reads go out as AXI4 bursts; stores drain through a write FIFO.
module dcache_mem_responder #(
  parameter int offset_width = 2,
  parameter int wbuf_depth   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            dcache_mem_req,
  input  logic                            dcache_mem_wr,
  input  logic [31:0]                     dcache_mem_addr,
  input  logic [31:0]                     dcache_mem_wdata,
  input  logic [3:0]                      dcache_mem_wstrb,
  input  logic                            dcache_mem_SUC,
  output logic                            mem_dcache_addrOK,
  output logic                            mem_dcache_dataOK,
  output logic [32*(1<<offset_width)-1:0] mem_dcache_rdata,
  output logic [31:0]                     m_araddr,
  output logic [7:0]                      m_arlen,
  output logic                            m_arvalid,
  input  logic                            m_arready,
  input  logic [31:0]                     m_rdata,
  input  logic                            m_rvalid,
  output logic                            m_rready,
  output logic [31:0]                     m_awaddr,
  output logic                            m_awvalid,
  input  logic                            m_awready,
  output logic [31:0]                     m_wdata,
  output logic [3:0]                      m_wstrb,
  output logic                            m_wlast,
  output logic                            m_wvalid,
  input  logic                            m_wready,
  input  logic                            m_bvalid,
  output logic                            m_bready
);
  localparam int LINE = 1 << offset_width;
  localparam int PW   = $clog2(wbuf_depth);

  localparam logic [1:0] R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2, R_DONE = 2'd3;
  localparam logic [1:0] W_IDLE = 2'd0, W_SEND = 2'd1, W_RESP = 2'd2;

  logic [1:0] rstate, wstate;

  logic [31:0] fifo_addr [wbuf_depth];
  logic [31:0] fifo_data [wbuf_depth];
  logic [3:0]  fifo_strb [wbuf_depth];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0]   count;
  logic fifo_empty, fifo_full, push, pop;
  logic wr_acc, rd_acc;

  logic                        suc_q;
  logic [offset_width-1:0]     widx_q, beat_q, ridx;
  logic                        last_beat;
  logic [32*LINE-1:0]          rline;
  logic                        aw_done, w_done;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PW+1)'(wbuf_depth));

  // Reads wait for an empty FIFO and an idle drain FSM, which keeps reads ordered after stores.
  assign wr_acc = !rst && dcache_mem_req && dcache_mem_wr && !fifo_full && (rstate == R_IDLE);
  assign rd_acc = !rst && dcache_mem_req && !dcache_mem_wr && fifo_empty &&
                  (wstate == W_IDLE) && (rstate == R_IDLE);
  assign mem_dcache_addrOK = wr_acc || rd_acc;

  assign push = wr_acc;
  assign pop  = (wstate == W_RESP) && m_bvalid;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wptr] <= dcache_mem_addr;
      fifo_data[wptr] <= dcache_mem_wdata;
      fifo_strb[wptr] <= dcache_mem_wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Strongly-ordered reads are single-beat and land on the addressed word only.
  assign ridx      = suc_q ? widx_q : beat_q;
  assign last_beat = suc_q || (beat_q == offset_width'(LINE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate   <= R_IDLE;
      m_araddr <= '0;
      m_arlen  <= '0;
      suc_q    <= 1'b0;
      widx_q   <= '0;
      beat_q   <= '0;
      rline    <= '0;
    end else begin
      case (rstate)
        R_IDLE: if (rd_acc) begin
          rstate   <= R_AR;
          m_araddr <= dcache_mem_SUC ? (dcache_mem_addr & ~32'd3)
                                     : (dcache_mem_addr & ~32'(LINE*4 - 1));
          m_arlen  <= dcache_mem_SUC ? 8'd0 : 8'(LINE - 1);
          suc_q    <= dcache_mem_SUC;
          widx_q   <= dcache_mem_addr[offset_width+1:2];
          beat_q   <= '0;
        end
        R_AR: if (m_arready) rstate <= R_DATA;
        R_DATA: if (m_rvalid) begin
          if (beat_q == '0) rline <= '0;
          rline[32*int'(ridx) +: 32] <= m_rdata;
          beat_q <= beat_q + 1'b1;
          if (last_beat) rstate <= R_DONE;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  assign m_arvalid         = (rstate == R_AR);
  assign m_rready          = (rstate == R_DATA);
  assign mem_dcache_dataOK = (rstate == R_DONE);
  assign mem_dcache_rdata  = rline;

  // AW and W complete independently; the response phase starts once both have handshaken.
  assign aw_done = !m_awvalid || m_awready;
  assign w_done  = !m_wvalid  || m_wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate    <= W_IDLE;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_awaddr  <= '0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
    end else begin
      case (wstate)
        W_IDLE: if (!fifo_empty) begin
          wstate    <= W_SEND;
          m_awvalid <= 1'b1;
          m_wvalid  <= 1'b1;
          m_awaddr  <= fifo_addr[rptr];
          m_wdata   <= fifo_data[rptr];
          m_wstrb   <= fifo_strb[rptr];
        end
        W_SEND: begin
          if (m_awvalid && m_awready) m_awvalid <= 1'b0;
          if (m_wvalid && m_wready)   m_wvalid  <= 1'b0;
          if (aw_done && w_done)      wstate    <= W_RESP;
        end
        W_RESP: if (m_bvalid) wstate <= W_IDLE;
        default: wstate <= W_IDLE;
      endcase
    end
  end

  assign m_bready = (wstate == W_RESP);
  assign m_wlast  = 1'b1;

endmodule

// File: doc/dcache_mem_responder.md
Name: dcache_mem_responder

Overview:
- Memory-side responder for the Dcache request interface (req/wr/addrOK/dataOK) that the Dcache main FSM initiates on.
- Accepts line refills, strongly-ordered uncached (SUC) reads and write-through stores; converts them to an AXI4 master port.
- Stores are buffered in a write FIFO. Reads return a whole line in one dataOK pulse.

Parameters:
offset_width, 2, log2 of 32-bit words per cache line; LINE = 2^offset_width words
wbuf_depth, 4, write FIFO entries; must be a power of 2, at least 2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
dcache_mem_req  in  1  request valid; held by the Dcache until accepted (writes) or until dataOK (reads)
dcache_mem_wr  in  1  1 = write, 0 = read
dcache_mem_addr  in  32  byte address
dcache_mem_wdata  in  32  store data
dcache_mem_wstrb  in  4  store byte enables
dcache_mem_SUC  in  1  strongly-ordered uncached access
mem_dcache_addrOK  out  1  one-cycle pulse: request (and write data) accepted
mem_dcache_dataOK  out  1  one-cycle pulse: mem_dcache_rdata valid
mem_dcache_rdata  out  32*LINE  returned line; word i at bits [32i+31:32i]
m_araddr  out  32  AXI read address
m_arlen  out  8  AXI burst length - 1
m_arvalid  out  1  AXI AR valid
m_arready  in  1  AXI AR ready
m_rdata  in  32  AXI read data
m_rvalid  in  1  AXI R valid
m_rready  out  1  AXI R ready
m_awaddr  out  32  AXI write address
m_awvalid  out  1  AXI AW valid
m_awready  in  1  AXI AW ready
m_wdata  out  32  AXI write data
m_wstrb  out  4  AXI write strobes
m_wlast  out  1  constant 1 (single-beat writes)
m_wvalid  out  1  AXI W valid
m_wready  in  1  AXI W ready
m_bvalid  in  1  AXI B valid
m_bready  out  1  AXI B ready

Behaviour:
- AXI constants, not exported: size = 4 bytes, burst = INCR, ID = 0. rresp/bresp are ignored.
- Reset values: every output 0; FIFO empty; both FSMs idle. A reset mid-burst abandons the transaction; the interconnect is reset with this block.
- Write accept, combinational: addrOK = req & wr & FIFO not full & read FSM in R_IDLE.
  - On addrOK: push {addr, wdata, wstrb} into the FIFO. The entry is visible to the drain FSM the next cycle.
  - FIFO full: addrOK stays 0 and the Dcache holds req.
- Read FSM states: R_IDLE, R_AR, R_DATA, R_DONE.
  - R_IDLE -> R_AR when req & !wr & FIFO empty & write FSM in W_IDLE. This gives read-after-write ordering. In that cycle: addrOK = 1; latch addr and SUC.
  - R_AR: arvalid = 1.
    - Cached: araddr = addr with low offset_width+2 bits cleared; arlen = LINE-1.
    - SUC: araddr = addr & ~3; arlen = 0.
    - Go to R_DATA on arready.
  - R_DATA: rready = 1; beat counter starts at 0.
    - Each rvalid writes rdata into line word[counter] and increments the counter.
    - SUC: the single beat goes to word[addr[offset_width+1:2]]; all other words are 0.
    - Go to R_DONE after the last beat (counter = arlen).
  - R_DONE: dataOK = 1 for exactly one cycle, rdata stable; -> R_IDLE. rdata holds its value until the next read's first beat.
- Write drain FSM states: W_IDLE, W_SEND, W_RESP.
  - W_IDLE -> W_SEND when the FIFO is not empty. Assert awvalid and wvalid together from the FIFO head.
  - W_SEND: track aw_done and w_done independently; each valid drops after its own handshake. When both are done (same cycle allowed) -> W_RESP.
  - W_RESP: bready = 1. On bvalid, pop the FIFO head -> W_IDLE. At most one write is outstanding.
- Simultaneous events:
  - Push and pop in the same cycle leave the count unchanged.
  - Push when full is impossible because addrOK is gated.
  - The FIFO pointers are offset_width-independent and wrap modulo wbuf_depth.
  - A read request while writes are pending waits, with addrOK = 0; the write accept path is also blocked while the read FSM is busy.

Test Plan:
- Refill, offset_width = 2: read at addr 0x1004, cached, arready immediate, R beats A0..A3 back-to-back -> araddr 0x1000, arlen 3; dataOK pulses 1 cycle after the 4th beat; rdata = {A3,A2,A1,A0}.
- SUC read at 0x2008 returning 0xDEADBEEF -> araddr 0x2008, arlen 0; rdata word2 = 0xDEADBEEF, other words 0.
- 5 back-to-back writes, wbuf_depth 4, awready held 0 -> 4 addrOK pulses, 5th stalls. Release awready/wready/bvalid -> writes drain in order with strobes preserved; 5th accepted once one entry pops.
- Write to 0x3000 then read of 0x3000 -> AR not issued until the B handshake of the write completes; read addrOK occurs after the FIFO is empty.
- AW and W ready on different cycles (wready 3 cycles after awready) -> each valid deasserts after its own handshake; single pop on bvalid.
- rst asserted during R_DATA -> next cycle all outputs 0, FSMs idle; a new request is accepted normally after rst drops.
